matrix_mul_param: RTL and testbench

Parametrised successor to the fixed 6x6 `matrix_mul` engine. It multiplies two signed square matrices of runtime size `sizes` x `sizes`, up to `MAX_SIZE`. A and B are streamed in row-major order over a single read port. Each element of C is produced by serial multiply-accumulate and written out on a write port. A `mode` input selects either C=A*B or C=A*B^T, and the block sits between the matrix RAM/bench and the result sink.

---
 rtl/matrix_mul_param.sv | 179 +++++++++++++++++
 tb/tb_matrix_mul_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mul_param.sv
// rtl/matrix_mul_param.sv - serial MAC square matrix multiplier, C=A*B or C=A*B^T, n up to MAX_SIZE
// Optional output saturation: define MATMUL_SAT_EN (default build wraps to OUT_W bits).
module matrix_mul_param #(
    parameter int DATA_W   = 16,
    parameter int MAX_SIZE = 8,
    parameter int OUT_W    = 2*DATA_W,
    parameter int SIZE_W   = $clog2(MAX_SIZE+1),
    parameter int CNT_W    = $clog2(MAX_SIZE*MAX_SIZE+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] sizes,
    input  logic              mode,
    input  logic [DATA_W-1:0] rdata,
    output logic              ren,
    output logic              raddr,
    output logic [OUT_W-1:0]  wdata,
    output logic              wen,
    output logic              finish,
    output logic [4:0]        state,
    output logic [CNT_W-1:0]  input_data_num,
    output logic [CNT_W-1:0]  out_data_num
);
    localparam int PROD_W = 2*DATA_W;
    localparam int ACC_W  = 2*DATA_W + $clog2(MAX_SIZE);
    localparam int DEPTH  = MAX_SIZE*MAX_SIZE;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_LOAD_A = 5'd1,
        S_LOAD_B = 5'd2,
        S_MAC    = 5'd3,
        S_WRITE  = 5'd4,
        S_DONE   = 5'd5
    } state_t;

    state_t st;
    logic [SIZE_W-1:0]        n_lat;
    logic                     mode_lat;
    logic [CNT_W-1:0]         last_idx;
    logic [SIZE_W-1:0]        i, j, k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] mem_a [DEPTH];
    logic signed [DATA_W-1:0] mem_b [DEPTH];

    logic [SIZE_W-1:0]        n_m1;
    logic [IDX_W-1:0]         a_idx, b_idx;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic [OUT_W-1:0]         out_val;
    logic                     start_ok;

    assign state    = st;
    assign n_m1     = n_lat - SIZE_W'(1);
    assign start_ok = start && (sizes != '0) && (sizes <= SIZE_W'(MAX_SIZE));

    // mode=1 walks row j of B, which is column j of B^T
    always_comb begin
        a_idx = IDX_W'(i) * IDX_W'(n_lat) + IDX_W'(k);
        if (mode_lat)
            b_idx = IDX_W'(j) * IDX_W'(n_lat) + IDX_W'(k);
        else
            b_idx = IDX_W'(k) * IDX_W'(n_lat) + IDX_W'(j);
    end

    assign prod     = PROD_W'(mem_a[a_idx]) * PROD_W'(mem_b[b_idx]);
    assign acc_next = ((k == '0) ? '0 : acc) + ACC_W'(prod);

    always_comb begin
`ifdef MATMUL_SAT_EN
        if (acc_next[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc_next[ACC_W-1]}})
            out_val = acc_next[OUT_W-1:0];
        else if (acc_next[ACC_W-1])
            out_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
            out_val = {1'b0, {(OUT_W-1){1'b1}}};
`else
        out_val = acc_next[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (st == S_LOAD_A)
            mem_a[input_data_num[IDX_W-1:0]] <= rdata;
        if (st == S_LOAD_B)
            mem_b[input_data_num[IDX_W-1:0]] <= rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= S_IDLE;
            ren            <= 1'b0;
            raddr          <= 1'b0;
            wen            <= 1'b0;
            finish         <= 1'b0;
            wdata          <= '0;
            input_data_num <= '0;
            out_data_num   <= '0;
            n_lat          <= '0;
            mode_lat       <= 1'b0;
            last_idx       <= '0;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            acc            <= '0;
        end else begin
            wen    <= 1'b0;
            finish <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start_ok) begin
                        n_lat          <= sizes;
                        mode_lat       <= mode;
                        last_idx       <= CNT_W'(sizes) * CNT_W'(sizes) - CNT_W'(1);
                        input_data_num <= '0;
                        out_data_num   <= '0;
                        i              <= '0;
                        j              <= '0;
                        k              <= '0;
                        ren            <= 1'b1;
                        raddr          <= 1'b0;
                        st             <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (input_data_num == last_idx) begin
                        input_data_num <= '0;
                        raddr          <= 1'b1;
                        st             <= S_LOAD_B;
                    end else begin
                        input_data_num <= input_data_num + CNT_W'(1);
                    end
                end
                S_LOAD_B: begin
                    if (input_data_num == last_idx) begin
                        input_data_num <= '0;
                        ren            <= 1'b0;
                        raddr          <= 1'b0;
                        st             <= S_MAC;
                    end else begin
                        input_data_num <= input_data_num + CNT_W'(1);
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (k == n_m1) begin
                        k     <= '0;
                        wen   <= 1'b1;
                        wdata <= out_val;
                        st    <= S_WRITE;
                    end else begin
                        k <= k + SIZE_W'(1);
                    end
                end
                S_WRITE: begin
                    out_data_num <= out_data_num + CNT_W'(1);
                    if (j == n_m1) begin
                        j <= '0;
                        if (i == n_m1) begin
                            i      <= '0;
                            finish <= 1'b1;
                            st     <= S_DONE;
                        end else begin
                            i  <= i + SIZE_W'(1);
                            st <= S_MAC;
                        end
                    end else begin
                        j  <= j + SIZE_W'(1);
                        st <= S_MAC;
                    end
                end
                S_DONE:  st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mul_param.sv
// tb/tb_matrix_mul_param.sv - directed self-checking bench for matrix_mul_param
module tb_matrix_mul_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  sizes = '0;
    logic        mode = 1'b0;
    logic [15:0] rdata;
    logic        ren, raddr, wen, finish;
    logic [31:0] wdata;
    logic [4:0]  state;
    logic [6:0]  input_data_num, out_data_num;

    logic [15:0] mem_a_tb [64];
    logic [15:0] mem_b_tb [64];

    int cmp_cnt = 0;
    int err_cnt = 0;

    int got_w[$];
    int fin_cyc;
    int gap_bad;
    int idx_bad;
    int ren_cnt;
    bit overlap;

    always #5 clk = ~clk;

    assign rdata = ren ? (raddr ? mem_b_tb[input_data_num[5:0]] : mem_a_tb[input_data_num[5:0]]) : 16'h0000;

    matrix_mul_param dut (
        .clk(clk), .rst(rst), .start(start), .sizes(sizes), .mode(mode),
        .rdata(rdata), .ren(ren), .raddr(raddr), .wdata(wdata), .wen(wen),
        .finish(finish), .state(state), .input_data_num(input_data_num),
        .out_data_num(out_data_num)
    );

    // Drives one run and records what the DUT did; cycle 1 is the period after the start edge.
    task automatic run_matrix(input int n, input bit md);
        int last_w;
        int idx_exp;
        got_w.delete();
        fin_cyc = -1; gap_bad = 0; idx_bad = 0; ren_cnt = 0; overlap = 0;
        last_w = -1; idx_exp = 0;
        @(negedge clk);
        start = 1'b1; sizes = 4'(n); mode = md;
        @(posedge clk);
        #1;
        start = 1'b0; sizes = 4'd0; mode = ~md;
        for (int cyc = 1; cyc <= 3000 && fin_cyc < 0; cyc++) begin
            @(negedge clk);
            if (ren) begin
                if (int'(input_data_num) != idx_exp || raddr != (ren_cnt >= n*n)) idx_bad++;
                idx_exp = (idx_exp == n*n-1) ? 0 : idx_exp + 1;
                ren_cnt++;
            end
            if (wen) begin
                got_w.push_back($signed(wdata));
                if (last_w >= 0 && cyc - last_w != n+1) gap_bad++;
                last_w = cyc;
                if (finish) overlap = 1'b1;
            end
            if (finish) fin_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (state !== 5'd0 || ren !== 1'b0 || raddr !== 1'b0 || wen !== 1'b0 || finish !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: state=%0d ren=%b raddr=%b wen=%b finish=%b, required all 0", state, ren, raddr, wen, finish);
        end
        cmp_cnt++;
        if (wdata !== 32'd0 || input_data_num !== 7'd0 || out_data_num !== 7'd0) begin
            err_cnt++;
            $display("FAIL reset_data: wdata=%0d in_num=%0d out_num=%0d, required 0", wdata, input_data_num, out_data_num);
        end
        rst = 1'b0;
    endtask

    task automatic load_small;
        for (int x = 0; x < 64; x++) begin mem_a_tb[x] = 16'h0; mem_b_tb[x] = 16'h0; end
        mem_a_tb[0] = 16'd1; mem_a_tb[1] = 16'd2; mem_a_tb[2] = 16'd3; mem_a_tb[3] = 16'd4;
        mem_b_tb[0] = 16'd5; mem_b_tb[1] = 16'd6; mem_b_tb[2] = 16'd7; mem_b_tb[3] = 16'd8;
    endtask

    task automatic test_mode0;
        int exp_c [4] = '{19, 22, 43, 50};
        load_small();
        run_matrix(2, 1'b0);
        cmp_cnt++;
        if (got_w.size() != 4) begin err_cnt++; $display("FAIL m0_count: writes=%0d, required 4", got_w.size()); end
        for (int x = 0; x < 4; x++) begin
            int g = (x < got_w.size()) ? got_w[x] : -12345;
            cmp_cnt++;
            if (g != exp_c[x]) begin err_cnt++; $display("FAIL m0_c%0d: got %0d, required %0d", x, g, exp_c[x]); end
        end
        cmp_cnt++;
        if (fin_cyc != 21) begin err_cnt++; $display("FAIL m0_finish_lat: got %0d, required 21", fin_cyc); end
        cmp_cnt++;
        if (gap_bad != 0 || overlap) begin err_cnt++; $display("FAIL m0_wen_spacing: bad_gaps=%0d overlap=%0d, required 0/0", gap_bad, overlap); end
        cmp_cnt++;
        if (idx_bad != 0 || ren_cnt != 8) begin err_cnt++; $display("FAIL m0_read: idx_bad=%0d ren_cycles=%0d, required 0/8", idx_bad, ren_cnt); end
        cmp_cnt++;
        if (out_data_num !== 7'd4 || state !== 5'd0) begin err_cnt++; $display("FAIL m0_end: out_num=%0d state=%0d, required 4/0", out_data_num, state); end
    endtask

    task automatic test_mode1;
        int exp_c [4] = '{17, 23, 39, 53};
        load_small();
        run_matrix(2, 1'b1);
        cmp_cnt++;
        if (got_w.size() != 4) begin err_cnt++; $display("FAIL m1_count: writes=%0d, required 4", got_w.size()); end
        for (int x = 0; x < 4; x++) begin
            int g = (x < got_w.size()) ? got_w[x] : -12345;
            cmp_cnt++;
            if (g != exp_c[x]) begin err_cnt++; $display("FAIL m1_c%0d: got %0d, required %0d", x, g, exp_c[x]); end
        end
        cmp_cnt++;
        if (fin_cyc != 21) begin err_cnt++; $display("FAIL m1_finish_lat: got %0d, required 21", fin_cyc); end
    endtask

    task automatic test_n6;
        int exp_c [36];
        for (int x = 0; x < 36; x++) begin
            mem_a_tb[x] = 16'($signed($urandom_range(2000)) - 1000);
            mem_b_tb[x] = 16'($signed($urandom_range(2000)) - 1000);
        end
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                int s = 0;
                for (int q = 0; q < 6; q++) begin
                    int av = $signed(mem_a_tb[r*6+q]);
                    int bv = $signed(mem_b_tb[q*6+c]);
                    s += av * bv;
                end
                exp_c[r*6+c] = s;
            end
        run_matrix(6, 1'b0);
        cmp_cnt++;
        if (got_w.size() != 36) begin err_cnt++; $display("FAIL n6_count: writes=%0d, required 36", got_w.size()); end
        for (int x = 0; x < 36; x++) begin
            int g = (x < got_w.size()) ? got_w[x] : -12345;
            cmp_cnt++;
            if (g != exp_c[x]) begin err_cnt++; $display("FAIL n6_c%0d: got %0d, required %0d", x, g, exp_c[x]); end
        end
        cmp_cnt++;
        if (out_data_num !== 7'd36) begin err_cnt++; $display("FAIL n6_out_num: got %0d, required 36", out_data_num); end
        cmp_cnt++;
        if (idx_bad != 0 || ren_cnt != 72) begin err_cnt++; $display("FAIL n6_read: idx_bad=%0d ren_cycles=%0d, required 0/72", idx_bad, ren_cnt); end
        cmp_cnt++;
        if (fin_cyc != 2*36 + 36*7 + 1) begin err_cnt++; $display("FAIL n6_finish_lat: got %0d, required %0d", fin_cyc, 2*36+36*7+1); end
    endtask

    task automatic test_saturation;
`ifdef MATMUL_SAT_EN
        int exp_v = 2147483647;
`else
        int exp_v = 0;
`endif
        int bad = 0;
        for (int x = 0; x < 64; x++) begin mem_a_tb[x] = 16'h8000; mem_b_tb[x] = 16'h8000; end
        run_matrix(8, 1'b0);
        cmp_cnt++;
        if (got_w.size() != 64) begin err_cnt++; $display("FAIL sat_count: writes=%0d, required 64", got_w.size()); end
        for (int x = 0; x < got_w.size(); x++) begin
            cmp_cnt++;
            if (got_w[x] != exp_v) begin
                err_cnt++;
                if (bad < 4) $display("FAIL sat_c%0d: got %0d, required %0d", x, got_w[x], exp_v);
                bad++;
            end
        end
        cmp_cnt++;
        if (out_data_num !== 7'd64) begin err_cnt++; $display("FAIL sat_out_num: got %0d, required 64", out_data_num); end
    endtask

    task automatic test_invalid_size;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            start = 1'b1; sizes = (p == 0) ? 4'd0 : 4'd9; mode = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                cmp_cnt++;
                if (state !== 5'd0 || ren !== 1'b0 || wen !== 1'b0 || finish !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL invalid_size%0d: state=%0d ren=%b wen=%b finish=%b, required 0", sizes, state, ren, wen, finish);
                end
            end
        end
        start = 1'b0; sizes = 4'd0;
    endtask

    task automatic test_reset_midrun;
        for (int x = 0; x < 64; x++) begin mem_a_tb[x] = 16'h7777; mem_b_tb[x] = 16'h7777; end
        @(negedge clk);
        start = 1'b1; sizes = 4'd2; mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        cmp_cnt++;
        if (state !== 5'd2) begin err_cnt++; $display("FAIL midrun_in_load_b: state=%0d, required 2", state); end
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if (state !== 5'd0 || ren !== 1'b0 || raddr !== 1'b0 || input_data_num !== 7'd0) begin
            err_cnt++;
            $display("FAIL midrun_abort: state=%0d ren=%b raddr=%b in_num=%0d, required 0", state, ren, raddr, input_data_num);
        end
        @(negedge clk);
        rst = 1'b0;
        load_small();
        run_matrix(2, 1'b0);
        cmp_cnt++;
        if (got_w.size() != 4 || got_w[0] != 19 || got_w[1] != 22 || got_w[2] != 43 || got_w[3] != 50) begin
            err_cnt++;
            $display("FAIL midrun_rerun: writes=%0d first=%0d, required 19,22,43,50", got_w.size(), (got_w.size() > 0) ? got_w[0] : -12345);
        end
        cmp_cnt++;
        if (fin_cyc != 21) begin err_cnt++; $display("FAIL midrun_finish_lat: got %0d, required 21", fin_cyc); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_n6();
        test_saturation();
        test_invalid_size();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
